// File: rtl/data_memory_ctrl.sv
// Word-addressed data memory with byte enables, registered read, range flagging
// and a dump engine that streams a fixed window of words out after dump_start.
module data_memory_ctrl #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned DEPTH     = 128,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DUMP_BASE = 50,
  parameter int unsigned DUMP_LEN  = 9
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ADDR_W-1:0]   address,
  input  logic                mem_read,
  input  logic                mem_write,
  input  logic [DATA_W/8-1:0] byte_en,
  input  logic [DATA_W-1:0]   input_data,
  output logic [DATA_W-1:0]   data,
  output logic                rd_valid,
  output logic                addr_err,
  output logic                ready,
  input  logic                dump_start,
  output logic [DATA_W-1:0]   dump_data,
  output logic                dump_valid,
  output logic                dump_done
);

  localparam int unsigned NumBytes = DATA_W / 8;
  localparam int unsigned IdxW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW     = $clog2(DUMP_LEN + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(DUMP_LEN - 1);

  typedef enum logic [1:0] {StIdle, StDump, StDone} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] data_d, dump_data_d;
  logic              rd_valid_d, addr_err_d, dump_valid_d, dump_done_d;
  logic              wr_en;
  logic              in_range;
  logic [IdxW-1:0]   idx, dump_idx;

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Full-width unsigned compare: high address bits never alias into the array.
  assign in_range = (address < ADDR_W'(DEPTH));
  assign idx      = address[IdxW-1:0];
  assign dump_idx = IdxW'(DUMP_BASE) + IdxW'(cnt_q);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    data_d       = data;
    dump_data_d  = dump_data;
    rd_valid_d   = 1'b0;
    addr_err_d   = 1'b0;
    dump_valid_d = 1'b0;
    dump_done_d  = 1'b0;
    wr_en        = 1'b0;
    ready        = 1'b0;

    unique case (state_q)
      StIdle: begin
        ready = 1'b1;
        if (dump_start) begin
          state_d = StDump;
          cnt_d   = '0;
        end
        // Read wins over a simultaneous write; the write is dropped.
        if (mem_read) begin
          if (in_range) begin
            data_d     = mem_q[idx];
            rd_valid_d = 1'b1;
          end else begin
            addr_err_d = 1'b1;
          end
        end else if (mem_write) begin
          if (in_range) begin
            wr_en = rst_n;
          end else begin
            addr_err_d = 1'b1;
          end
        end
      end
      StDump: begin
        dump_data_d  = mem_q[dump_idx];
        dump_valid_d = 1'b1;
        cnt_d        = cnt_q + CntW'(1);
        if (cnt_q == LastCnt) begin
          state_d = StDone;
        end
      end
      StDone: begin
        dump_done_d = 1'b1;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      data       <= '0;
      rd_valid   <= 1'b0;
      addr_err   <= 1'b0;
      dump_data  <= '0;
      dump_valid <= 1'b0;
      dump_done  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      data       <= data_d;
      rd_valid   <= rd_valid_d;
      addr_err   <= addr_err_d;
      dump_data  <= dump_data_d;
      dump_valid <= dump_valid_d;
      dump_done  <= dump_done_d;
    end
  end

  // Array has no reset so its contents survive rst_n.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < NumBytes; i++) begin
        if (byte_en[i]) begin
          mem_q[idx][8*i +: 8] <= input_data[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Random and directed stimulus for data_memory_ctrl, checked every cycle against
// a transaction-level model of the memory and dump stream.
module tb_data_memory_ctrl;

  localparam int DW    = 32;
  localparam int DEPTH = 128;
  localparam int BASE  = 50;
  localparam int LEN   = 9;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [31:0]   address;
  logic          mem_read, mem_write, dump_start;
  logic [3:0]    byte_en;
  logic [DW-1:0] input_data;
  logic [DW-1:0] data, dump_data;
  logic          rd_valid, addr_err, ready, dump_valid, dump_done;

  int checks = 0;
  int errors = 0;

  data_memory_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .address    (address),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .byte_en    (byte_en),
    .input_data (input_data),
    .data       (data),
    .rd_valid   (rd_valid),
    .addr_err   (addr_err),
    .ready      (ready),
    .dump_start (dump_start),
    .dump_data  (dump_data),
    .dump_valid (dump_valid),
    .dump_done  (dump_done)
  );

  always #5 clk = ~clk;

  // Reference model: memory contents plus expected registered outputs.
  logic [DW-1:0] m [DEPTH];
  logic [DW-1:0] e_data, e_dump_data;
  logic          e_rd_valid, e_addr_err, e_dump_valid, e_dump_done;
  int            phase;  // 0 idle, 1..LEN emitting word phase-1, LEN+1 done pulse

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    e_data = '0; e_dump_data = '0;
    e_rd_valid = 0; e_addr_err = 0; e_dump_valid = 0; e_dump_done = 0;
    phase = 0;
  endtask

  task automatic model_step();
    e_rd_valid = 0; e_addr_err = 0; e_dump_valid = 0; e_dump_done = 0;
    if (phase == 0) begin
      if (mem_read) begin
        if (address < DEPTH) begin
          e_data = m[address]; e_rd_valid = 1;
        end else e_addr_err = 1;
      end else if (mem_write) begin
        if (address < DEPTH) begin
          for (int b = 0; b < 4; b++)
            if (byte_en[b]) m[address][8*b +: 8] = input_data[8*b +: 8];
        end else e_addr_err = 1;
      end
      if (dump_start) phase = 1;
    end else if (phase <= LEN) begin
      e_dump_data = m[BASE + phase - 1];
      e_dump_valid = 1;
      phase++;
    end else begin
      e_dump_done = 1;
      phase = 0;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("ready", {31'b0, ready}, {31'b0, phase == 0});
      chk("data", data, e_data);
      chk("rd_valid", {31'b0, rd_valid}, {31'b0, e_rd_valid});
      chk("addr_err", {31'b0, addr_err}, {31'b0, e_addr_err});
      chk("dump_valid", {31'b0, dump_valid}, {31'b0, e_dump_valid});
      chk("dump_done", {31'b0, dump_done}, {31'b0, e_dump_done});
      if (e_dump_valid) chk("dump_data", dump_data, e_dump_data);
    end
  end

  // Drive one edge worth of inputs, then return 1 time unit after the edge.
  task automatic req(input logic rd, input logic wr, input logic [3:0] be,
                     input logic [31:0] a, input logic [DW-1:0] d, input logic st);
    mem_read = rd; mem_write = wr; byte_en = be; address = a; input_data = d; dump_start = st;
    @(posedge clk); #1;
    mem_read = 0; mem_write = 0; byte_en = 0; dump_start = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    rst_n = 0; mem_read = 0; mem_write = 0; byte_en = 0; address = 0;
    input_data = 0; dump_start = 0;
    #1;
    chk("reset_data", data, 0);
    chk("reset_dump_data", dump_data, 0);
    chk("reset_ready", {31'b0, ready}, 1);
    chk("reset_flags", {28'b0, rd_valid, addr_err, dump_valid, dump_done}, 0);
    #11 rst_n = 1;
    @(posedge clk); #1;

    for (int i = 0; i < DEPTH; i++) req(0, 1, 4'hF, i, $urandom, 0);

    req(0, 1, 4'hF, 5, 32'hDEADBEEF, 0);
    req(1, 0, 4'h0, 5, 0, 0);
    chk("rd5_data", data, 32'hDEADBEEF);
    chk("rd5_valid", {31'b0, rd_valid}, 1);
    idle(1);
    chk("rd5_pulse_end", {31'b0, rd_valid}, 0);
    chk("rd5_hold", data, 32'hDEADBEEF);

    req(0, 1, 4'b0001, 5, 32'h000000AA, 0);
    req(1, 0, 4'h0, 5, 0, 0);
    chk("byte_write", data, 32'hDEADBEAA);

    req(0, 1, 4'hF, 7, 32'h1001, 0);
    req(1, 1, 4'hF, 7, 32'h5, 0);
    chk("rw_same_edge", data, 32'h1001);
    req(1, 0, 4'h0, 7, 0, 0);
    chk("rw_dropped", data, 32'h1001);

    req(1, 0, 4'h0, 200, 0, 0);
    chk("oor_err", {31'b0, addr_err}, 1);
    chk("oor_no_valid", {31'b0, rd_valid}, 0);
    chk("oor_data", data, 32'h1001);
    req(1, 0, 4'h0, 128, 0, 0);
    chk("oor_128", {31'b0, addr_err}, 1);
    req(1, 0, 4'h0, 127, 0, 0);
    chk("edge_127", {30'b0, rd_valid, addr_err}, 2);

    for (int i = 0; i < LEN; i++) req(0, 1, 4'hF, BASE + i, i + 1, 0);
    req(0, 0, 4'h0, 0, 0, 1);
    chk("dump_ready_low", {31'b0, ready}, 0);
    for (int j = 1; j <= LEN; j++) begin
      if (j == 3) begin
        mem_write = 1; address = 52; input_data = 32'hFFFF; byte_en = 4'hF;
      end
      @(posedge clk); #1;
      mem_write = 0; byte_en = 0;
      chk("dump_word_valid", {31'b0, dump_valid}, 1);
      chk("dump_word", dump_data, 32'(j));
    end
    idle(1);
    chk("dump_done_pulse", {30'b0, dump_done, dump_valid}, 2);
    idle(1);
    chk("dump_done_end", {30'b0, dump_done, ready}, 1);
    req(1, 0, 4'h0, 52, 0, 0);
    chk("write_during_dump", data, 3);

    req(0, 0, 4'h0, 0, 0, 1);
    idle(3);
    chk("third_word", dump_data, 3);
    #1 rst_n = 0;
    #1;
    chk("rst_dump_valid", {31'b0, dump_valid}, 0);
    chk("rst_dump_done", {31'b0, dump_done}, 0);
    chk("rst_ready", {31'b0, ready}, 1);
    #1 rst_n = 1;
    @(posedge clk); #1;
    for (int i = 0; i < LEN; i++) begin
      req(1, 0, 4'h0, BASE + i, 0, 0);
      chk("survive_reset", data, 32'(i + 1));
    end

    for (int n = 0; n < 1500; n++) begin
      int r;
      logic [31:0] a;
      r = $urandom_range(0, 9);
      if (r == 0) a = $urandom;
      else if (r == 1) a = 128 + $urandom_range(0, 20);
      else a = $urandom_range(0, DEPTH - 1);
      req($urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)),
          a, $urandom, $urandom_range(0, 39) == 0);
    end
    idle(LEN + 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
